// File: rtl/flash_pkg.sv
// Shared definitions for the serial-flash command sequencers: opcodes,
// transmitter transaction tags and the sequencer state encoding.
package flash_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_CE   = 8'hC7;

  localparam logic [1:0] SPI_CMD_NONE = 2'd0;
  localparam logic [1:0] SPI_CMD_WREN = 2'd1;
  localparam logic [1:0] SPI_CMD_CE   = 2'd2;

  // IDLE is the all-zero code so the eight active states are one-hot in 8 bits.
  typedef enum logic [7:0] {
    ST_IDLE    = 8'h00,
    ST_WREN_ST = 8'h01,
    ST_WREN_WT = 8'h02,
    ST_GAP     = 8'h04,
    ST_CE_ST   = 8'h08,
    ST_CE_WT   = 8'h10,
    ST_ERS_WT  = 8'h20,
    ST_DONE    = 8'h40,
    ST_ERR     = 8'h80
  } flash_state_e;

  function automatic logic is_start_state(input flash_state_e s);
    return (s == ST_WREN_ST) || (s == ST_CE_ST);
  endfunction

endpackage

// File: rtl/flash_cyc_timer.sv
// Loadable down-counter; tc_o pulses while enabled with the count at zero,
// so loading N-1 gives a terminal pulse on the Nth enabled cycle.
module flash_cyc_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/flash_erase_ctrl.sv
// Chip-erase sequencer: WREN, CS-high gap, Chip Erase, optional erase hold-off.
// Define FLASH_ERASE_CTRL_ERASE_WAIT_EN to wait ERASE_CYC cycles before reporting done.
module flash_erase_ctrl
  import flash_pkg::*;
#(
  parameter logic [7:0]  CS_GAP_CYC = 8'd4,
  parameter logic [31:0] ERASE_CYC  = 32'd1_250_000_000,
  parameter logic [7:0]  SPI_TO_CYC = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       erase_req,
  input  logic       spi_done,
  output logic       spi_start,
  output logic [1:0] spi_cmd,
  output logic [7:0] spi_wrdata,
  output logic       erase_busy,
  output logic       erase_done,
  output logic       erase_err
);

  flash_state_e state_q;
  logic [7:0]   spi_wrdata_q;
  logic [1:0]   spi_cmd_q;
  logic         in_wt;
  logic         wd_tc;
  logic         gap_tc;

  assign in_wt = (state_q == ST_WREN_WT) || (state_q == ST_CE_WT);

  flash_cyc_timer #(.WIDTH(8)) u_wd_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (is_start_state(state_q)),
    .load_val_i (SPI_TO_CYC - 8'd1),
    .en_i       (in_wt),
    .tc_o       (wd_tc)
  );

  flash_cyc_timer #(.WIDTH(8)) u_gap_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     ((state_q == ST_WREN_WT) && spi_done),
    .load_val_i (CS_GAP_CYC - 8'd1),
    .en_i       (state_q == ST_GAP),
    .tc_o       (gap_tc)
  );

`ifdef FLASH_ERASE_CTRL_ERASE_WAIT_EN
  logic ers_tc;

  flash_cyc_timer #(.WIDTH(32)) u_ers_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     ((state_q == ST_CE_WT) && spi_done),
    .load_val_i (ERASE_CYC - 32'd1),
    .en_i       (state_q == ST_ERS_WT),
    .tc_o       (ers_tc)
  );
`else
  // The erase hold-off is compiled out, so ERASE_CYC has no effect here.
  if (ERASE_CYC == 32'd0) begin : g_ers_unused
  end
`endif

  // spi_done only counts in the wait states; a done on the timeout cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      spi_wrdata_q <= 8'h00;
      spi_cmd_q    <= SPI_CMD_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (erase_req) begin
            state_q      <= ST_WREN_ST;
            spi_wrdata_q <= CMD_WREN;
            spi_cmd_q    <= SPI_CMD_WREN;
          end
        end
        ST_WREN_ST: state_q <= ST_WREN_WT;
        ST_WREN_WT: begin
          if (spi_done) begin
            state_q <= ST_GAP;
          end else if (wd_tc) begin
            state_q <= ST_ERR;
          end
        end
        ST_GAP: begin
          if (gap_tc) begin
            state_q      <= ST_CE_ST;
            spi_wrdata_q <= CMD_CE;
            spi_cmd_q    <= SPI_CMD_CE;
          end
        end
        ST_CE_ST: state_q <= ST_CE_WT;
        ST_CE_WT: begin
          if (spi_done) begin
`ifdef FLASH_ERASE_CTRL_ERASE_WAIT_EN
            state_q <= ST_ERS_WT;
`else
            state_q <= ST_DONE;
`endif
          end else if (wd_tc) begin
            state_q <= ST_ERR;
          end
        end
`ifdef FLASH_ERASE_CTRL_ERASE_WAIT_EN
        ST_ERS_WT: begin
          if (ers_tc) begin
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_start  = is_start_state(state_q);
  assign spi_wrdata = spi_wrdata_q;
  assign spi_cmd    = spi_cmd_q;
  assign erase_busy = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign erase_done = (state_q == ST_DONE);
  assign erase_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Self-checking bench for flash_erase_ctrl: directed scenarios plus random
// traffic, compared every cycle against a schedule-based model of the sequencer.
`timescale 1ns/1ps
module tb_flash_erase_ctrl;

  localparam int GAP = 4;
  localparam int ERS = 100;
  localparam int TO  = 40;
`ifdef FLASH_ERASE_CTRL_ERASE_WAIT_EN
  localparam int HOLD = ERS;
`else
  localparam int HOLD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       erase_req = 1'b0;
  logic       spi_done = 1'b0;
  logic       spi_start;
  logic [1:0] spi_cmd;
  logic [7:0] spi_wrdata;
  logic       erase_busy;
  logic       erase_done;
  logic       erase_err;

  flash_erase_ctrl #(
    .CS_GAP_CYC (8'd4),
    .ERASE_CYC  (32'd100),
    .SPI_TO_CYC (8'd40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .erase_req  (erase_req),
    .spi_done   (spi_done),
    .spi_start  (spi_start),
    .spi_cmd    (spi_cmd),
    .spi_wrdata (spi_wrdata),
    .erase_busy (erase_busy),
    .erase_done (erase_done),
    .erase_err  (erase_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: one operation is a schedule of absolute cycles (starts, finish).
  bit       mValid = 0;
  bit       mActive = 0;
  bit       mErr = 0;
  int       mPhase = 0;
  int       mS1 = -1;
  int       mS2 = -1;
  int       mFin = -1;
  logic [7:0] mWr = 8'h00;
  logic [1:0] mCmd = 2'd0;

  // Scenario controls and transmitter emulation.
  bit forceRst = 0;
  bit randMode = 0;
  bit txRand = 0;
  int txLat = 12;
  int pend[$];
  int reqCycles[$];
  int spurCycles[$];
  int rstFrom = -1;
  int rstTo = -1;

  // Observed DUT events, used for the literal timing pins.
  int starts[$];
  int doneAt = -1;
  int errAt = -1;
  int busyFirst = -1;
  int busyLast = -1;

  function automatic bit inQ(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus();
    rst_n = !(forceRst || (cyc >= rstFrom && cyc <= rstTo));
    if (randMode && $urandom_range(0, 799) == 0) rst_n = 1'b0;
    erase_req = inQ(reqCycles, cyc) || (randMode && $urandom_range(0, 24) == 0);
    spi_done  = inQ(pend, cyc) || inQ(spurCycles, cyc) ||
                (randMode && $urandom_range(0, 39) == 0);
  endtask

  // Advance the model by the inputs applied during cycle cyc.
  task automatic modelStep();
    if (!rst_n) begin
      mValid = 1; mActive = 0; mPhase = 0; mErr = 0;
      mS1 = -1; mS2 = -1; mFin = -1; mWr = 8'h00; mCmd = 2'd0;
      return;
    end
    if (!mValid) return;
    if (mActive) begin
      if (mPhase == 1) begin
        if (spi_done && cyc > mS1) begin
          mS2 = cyc + GAP + 1; mPhase = 2;
        end else if (cyc == mS1 + TO) begin
          mFin = cyc + 1; mErr = 1; mPhase = 3;
        end
      end else if (mPhase == 2 && cyc > mS2) begin
        if (spi_done) begin
          mFin = cyc + 1 + HOLD; mPhase = 3;
        end else if (cyc == mS2 + TO) begin
          mFin = cyc + 1; mErr = 1; mPhase = 3;
        end
      end
    end
    if (!mActive && erase_req) begin
      mActive = 1; mPhase = 1; mErr = 0;
      mS1 = cyc + 1; mS2 = -1; mFin = -1;
    end else if (mActive && mPhase == 3 && cyc == mFin) begin
      mActive = 0;
    end
  endtask

  task automatic tick();
    bit expStart, expBusy, expDone, expErr;
    @(posedge clk);
    #1;
    if (mValid) begin
      if (mActive && cyc == mS1) begin mWr = 8'h06; mCmd = 2'd1; end
      if (mActive && cyc == mS2) begin mWr = 8'hC7; mCmd = 2'd2; end
      expStart = mActive && (cyc == mS1 || cyc == mS2);
      expBusy  = mActive && !(mPhase == 3 && cyc == mFin);
      expDone  = mActive && mPhase == 3 && cyc == mFin && !mErr;
      expErr   = mActive && mPhase == 3 && cyc == mFin && mErr;
      checkOutput("spi_start", int'(spi_start), int'(expStart));
      checkOutput("erase_busy", int'(erase_busy), int'(expBusy));
      checkOutput("erase_done", int'(erase_done), int'(expDone));
      checkOutput("erase_err", int'(erase_err), int'(expErr));
      checkOutput("spi_wrdata", int'(spi_wrdata), int'(mWr));
      checkOutput("spi_cmd", int'(spi_cmd), int'(mCmd));
    end
    if (spi_start === 1'b1) begin
      starts.push_back(cyc);
      if (txRand) pend.push_back(cyc + int'($urandom_range(1, 45)));
      else if (txLat >= 0) pend.push_back(cyc + txLat);
    end
    if (erase_done === 1'b1) doneAt = cyc;
    if (erase_err === 1'b1 && errAt < 0) errAt = cyc;
    if (erase_busy === 1'b1) begin
      if (busyFirst < 0) busyFirst = cyc;
      busyLast = cyc;
    end
    applyStimulus();
    modelStep();
    cyc++;
  endtask

  // Reset, pin the reset values, then renumber so the next cycle is cycle 0.
  task automatic startScenario(input int lat);
    forceRst = 1;
    repeat (3) tick();
    checkOutput("rst_spi_start", int'(spi_start), 0);
    checkOutput("rst_busy", int'(erase_busy), 0);
    checkOutput("rst_wrdata", int'(spi_wrdata), 0);
    checkOutput("rst_cmd", int'(spi_cmd), 0);
    forceRst = 0;
    randMode = 0; txRand = 0; txLat = lat;
    pend.delete(); reqCycles.delete(); spurCycles.delete(); starts.delete();
    rstFrom = -1; rstTo = -1;
    doneAt = -1; errAt = -1; busyFirst = -1; busyLast = -1;
    cyc = 0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Nominal erase.
    startScenario(12);
    reqCycles.push_back(0);
    runCycles(60 + HOLD);
    checkOutput("nom_start_count", starts.size(), 2);
    checkOutput("nom_start1", starts.size() > 0 ? starts[0] : -1, 1);
    checkOutput("nom_start2", starts.size() > 1 ? starts[1] : -1, 18);
    checkOutput("nom_done", doneAt, 31 + HOLD);
    checkOutput("nom_busy_first", busyFirst, 1);
    checkOutput("nom_busy_last", busyLast, 30 + HOLD);
    checkOutput("nom_err", errAt, -1);

    // Requests while busy and on the DONE cycle are dropped.
    startScenario(12);
    reqCycles = '{0, 5, 50, 31 + HOLD, 32 + HOLD};
    runCycles(90 + 2 * HOLD);
    checkOutput("busy_start_count", starts.size(), 4);
    checkOutput("busy_restart", starts.size() > 2 ? starts[2] : -1, 33 + HOLD);

    // Watchdog: the transmitter never answers.
    startScenario(-1);
    reqCycles.push_back(0);
    runCycles(60);
    checkOutput("wd_err", errAt, 42);
    checkOutput("wd_start_count", starts.size(), 1);
    checkOutput("wd_done", doneAt, -1);

    // Done on the timeout cycle wins.
    startScenario(40);
    reqCycles.push_back(0);
    runCycles(110 + HOLD);
    checkOutput("to40_done", doneAt, 87 + HOLD);
    checkOutput("to40_err", errAt, -1);

    // Done one cycle late is a fault.
    startScenario(41);
    reqCycles.push_back(0);
    runCycles(60);
    checkOutput("to41_err", errAt, 42);

    // Spurious done before the request and during the gap.
    startScenario(12);
    spurCycles = '{0, 1, 2, 3, 18, 19, 20, 21};
    reqCycles.push_back(4);
    runCycles(60 + HOLD);
    checkOutput("spur_start1", starts.size() > 0 ? starts[0] : -1, 5);
    checkOutput("spur_start2", starts.size() > 1 ? starts[1] : -1, 22);
    checkOutput("spur_done", doneAt, 35 + HOLD);

    // Reset in the middle of an operation, then a fresh request.
    startScenario(12);
    reqCycles = '{0, 70};
    rstFrom = 60; rstTo = 61;
    runCycles(130 + HOLD);
    checkOutput("mid_start_count", starts.size(), 4);
    checkOutput("mid_start3", starts.size() > 2 ? starts[2] : -1, 71);
    checkOutput("mid_start4", starts.size() > 3 ? starts[3] : -1, 88);
    checkOutput("mid_done", doneAt, 101 + HOLD);

    // Random traffic: requests, latencies, spurious dones and resets.
    startScenario(12);
    randMode = 1; txRand = 1;
    runCycles(4000);
    randMode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
